bounce_generator: RTL and testbench
===================================

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter counterwidth, default 4: bounce counter width in bits; SHALL satisfy 2^counterwidth > bouncetime.
REQ-002 Parameter bouncetime, default 8: bounce duration in clock cycles; legal range 1..2^counterwidth-1.
REQ-003 Parameter lfsrseed, default 8'hA5: LFSR reset value; SHALL be nonzero.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cleansignal  input  1  ideal switch level to emulate; already in the clk domain.
REQ-007 bounceenable  input  1  1 = emulate bounce on each level change; 0 = pass-through.
REQ-008 noisysignal  output  1  registered emulated contact output, bouncing then settling.
REQ-009 busy  output  1  registered; 1 while in BOUNCE.
REQ-010 settled  output  1  registered; one-cycle pulse on the edge noisysignal takes its final level.

Function
REQ-011 Internal state: target (1 bit), counter (counterwidth bits), lfsr (8 bits), state in {IDLE, BOUNCE}.
REQ-012 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, and SHALL shift on every non-reset edge in both states; bounce value = lfsr[0] as it stands before that edge.
REQ-013 Change detect: change = (cleansignal != target); target <= cleansignal on every edge.
REQ-014 IDLE, change, bounceenable=1: state <= BOUNCE, counter <= 0, busy <= 1, noisysignal <= lfsr[0], settled <= 0.
REQ-015 IDLE, change, bounceenable=0: stay IDLE, noisysignal <= cleansignal, settled <= 1 (one-cycle latency).
REQ-016 IDLE, no change: noisysignal <= target, settled <= 0, busy <= 0.
REQ-017 BOUNCE, no change, counter < bouncetime-1: counter <= counter+1, noisysignal <= lfsr[0].
REQ-018 BOUNCE, no change, counter == bouncetime-1: noisysignal <= target, state <= IDLE, busy <= 0, settled <= 1, counter <= 0.
REQ-019 Bounce values SHALL therefore appear for exactly bouncetime cycles; final level is stable from the edge bouncetime cycles after the detecting edge.
REQ-020 BOUNCE, change (mid-bounce reversal): counter <= 0, noisysignal <= lfsr[0], stay BOUNCE, no settled pulse; bounce window restarts against the new target.
REQ-021 Change on the settling edge: REQ-020 takes priority over REQ-018.
REQ-022 bounceenable deasserted during BOUNCE: current bounce completes normally; sampled only on a change in IDLE.
REQ-023 settled and busy SHALL never both be 1 in the same cycle.
REQ-024 counter SHALL never exceed bouncetime-1; no wrap-around.

Reset
REQ-025 While reset=1 at an edge: state <= IDLE, target <= 0, counter <= 0, lfsr <= lfsrseed, noisysignal <= 0, busy <= 0, settled <= 0.
REQ-026 Reset mid-bounce SHALL abort the bounce with no settled pulse; reset overrides all other conditions.
REQ-027 If cleansignal=1 at reset release, the first post-reset edge SHALL treat it as a change (REQ-014/015).

Structure
REQ-028 Shared include file holds: IDLE/BOUNCE encodings (1 bit), LFSR tap mask 8'hB8, default lfsrseed.
REQ-029 One sub-module, lfsr8 (clk, reset, seed parameter, 8-bit state output), instantiated once; remaining logic lives in bounce_generator.
REQ-030 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Verification
REQ-031 Reset, hold cleansignal=0 for 20 cycles -> noisysignal=0, busy=0, settled=0 throughout; lfsr sequence matches golden model from 8'hA5.
REQ-032 bouncetime=8, cleansignal 0->1 at edge E -> busy=1 for edges E..E+7, noisysignal equals golden lfsr[0] sequence, noisysignal=1 and settled=1 at E+8, settled=0 at E+9.
REQ-033 Reversal: 0->1 at E, 1->0 at E+3 -> counter restarts, no settled pulse before E+11; noisysignal=0, settled=1 at E+11.
REQ-034 bounceenable=0, cleansignal toggled 0->1->0 every 4 cycles -> noisysignal follows with exactly 1-cycle latency, settled pulse per edge, busy always 0.
REQ-035 reset asserted at E+4 of a bounce -> next cycle noisysignal=0, busy=0, settled=0, lfsr=8'hA5; bounce never completes.
REQ-036 Closed loop: feed noisysignal into the team's input conditioner (waittime 3) across 10 random-spaced transitions -> exactly one positive and one negative edge pulse per clean transition.

Source files
------------

// File: rtl/bounce_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bounce_generator_pkg
// Description : Shared definitions for the contact-bounce emulator: FSM state
//               encodings, LFSR tap mask, default LFSR seed and the LFSR
//               next-state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bounce_generator_pkg;

    // One-bit state encodings for the emulator FSM.
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_bounce = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = c_st_idle,
        ST_BOUNCE = c_st_bounce
    } state_t;

    // Tap mask for x^8 + x^6 + x^5 + x^4 + 1 with a left-shifting register
    // (bits 7,5,4,3 feed the XOR that enters at bit 0).
    localparam logic [7:0] c_lfsr_taps    = 8'hB8;
    localparam logic [7:0] c_default_seed = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & c_lfsr_taps)};
    endfunction

endpackage : bounce_generator_pkg
`default_nettype wire

// File: rtl/bounce_generator_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR, free running on every non-reset edge.
// Ports       : clk   - clock
//               reset - synchronous active-high reset, loads SEED
//               state - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import bounce_generator_pkg::*;
#(
    parameter logic [7:0] SEED = c_default_seed
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] state
);

    logic [7:0] r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule : lfsr8
`default_nettype wire

// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module      : bounce_generator
// Description : Emulates a bouncing mechanical contact. On each level change
//               of cleansignal the output shows pseudo-random LFSR bits for
//               bouncetime cycles, then settles to the new level. With
//               bounceenable low the level is passed through with one cycle
//               of latency.
// Ports       : clk          - clock
//               reset        - synchronous active-high reset
//               cleansignal  - ideal switch level (clk domain)
//               bounceenable - 1 = emulate bounce, 0 = pass-through
//               noisysignal  - registered emulated contact output
//               busy         - registered, high while bouncing
//               settled      - registered one-cycle pulse on final level
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_generator
    import bounce_generator_pkg::*;
#(
    parameter int         counterwidth = 4,
    parameter int         bouncetime   = 8,
    parameter logic [7:0] lfsrseed     = c_default_seed
) (
    input  logic clk,
    input  logic reset,
    input  logic cleansignal,
    input  logic bounceenable,
    output logic noisysignal,
    output logic busy,
    output logic settled
);

    localparam logic [counterwidth-1:0] c_last = counterwidth'(bouncetime - 1);

    logic [7:0]              w_lfsr;
    logic                    w_lfsr_unused;
    logic                    w_change;
    state_t                  r_state;
    logic                    r_target;
    logic [counterwidth-1:0] r_counter;
    logic                    r_noisy;
    logic                    r_busy;
    logic                    r_settled;

    lfsr8 #(
        .SEED  (lfsrseed)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (w_lfsr)
    );

    // Only bit 0 drives the bounce pattern.
    assign w_lfsr_unused = ^w_lfsr[7:1];

    // target holds the previous clean level; target resets to 0 so a high
    // clean level at reset release is seen as a change.
    assign w_change = (cleansignal != r_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_target  <= 1'b0;
            r_counter <= '0;
            r_noisy   <= 1'b0;
            r_busy    <= 1'b0;
            r_settled <= 1'b0;
        end else begin
            r_target <= cleansignal;
            case (r_state)
                ST_IDLE: begin
                    if (w_change && bounceenable) begin
                        r_state   <= ST_BOUNCE;
                        r_counter <= '0;
                        r_busy    <= 1'b1;
                        r_noisy   <= w_lfsr[0];
                        r_settled <= 1'b0;
                    end else if (w_change) begin
                        r_noisy   <= cleansignal;
                        r_settled <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_noisy   <= r_target;
                        r_settled <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                ST_BOUNCE: begin
                    // A reversal restarts the window and wins over settling.
                    if (w_change) begin
                        r_counter <= '0;
                        r_noisy   <= w_lfsr[0];
                        r_busy    <= 1'b1;
                        r_settled <= 1'b0;
                    end else if (r_counter == c_last) begin
                        r_state   <= ST_IDLE;
                        r_counter <= '0;
                        r_noisy   <= r_target;
                        r_busy    <= 1'b0;
                        r_settled <= 1'b1;
                    end else begin
                        r_counter <= r_counter + 1'b1;
                        r_noisy   <= w_lfsr[0];
                        r_busy    <= 1'b1;
                        r_settled <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_counter <= '0;
                    r_busy    <= 1'b0;
                    r_settled <= 1'b0;
                end
            endcase
        end
    end

    assign noisysignal = r_noisy;
    assign busy        = r_busy;
    assign settled     = r_settled;

endmodule : bounce_generator
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_generator
// Description : Directed self-checking bench for bounce_generator with an
//               independent golden LFSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cleansignal = 1'b0;
    logic bounceenable = 1'b1;
    logic noisysignal;
    logic busy;
    logic settled;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] g_lfsr = 8'h00;
    logic       g_pre  = 1'b0;

    bounce_generator #(
        .counterwidth (4),
        .bouncetime   (8),
        .lfsrseed     (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cleansignal  (cleansignal),
        .bounceenable (bounceenable),
        .noisysignal  (noisysignal),
        .busy         (busy),
        .settled      (settled)
    );

    always #5 clk = ~clk;

    // Golden LFSR: x^8+x^6+x^5+x^4+1, left shift, seed 8'hA5.
    // g_pre is lfsr[0] as it stood before the most recent edge.
    always @(posedge clk) begin
        g_pre = g_lfsr[0];
        if (reset) g_lfsr = 8'hA5;
        else       g_lfsr = {g_lfsr[6:0], g_lfsr[7] ^ g_lfsr[5] ^ g_lfsr[4] ^ g_lfsr[3]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cleansignal = 1'b0; bounceenable = 1'b1;
        step(); step();
        n_checks++; if (noisysignal !== 1'b0) begin n_fail++; $display("FAIL reset_noisy: got %b expected 0", noisysignal); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b expected 0", settled); end
        n_checks++; if (dut.w_lfsr !== 8'hA5) begin n_fail++; $display("FAIL reset_lfsr: got %h expected a5", dut.w_lfsr); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (noisysignal !== 1'b0 || busy !== 1'b0 || settled !== 1'b0) begin
                n_fail++; $display("FAIL idle_outputs cyc %0d: got n=%b b=%b s=%b expected 000", i, noisysignal, busy, settled);
            end
            n_checks++; if (dut.w_lfsr !== g_lfsr) begin
                n_fail++; $display("FAIL idle_lfsr cyc %0d: got %h expected %h", i, dut.w_lfsr, g_lfsr);
            end
        end
    endtask

    task automatic test_bounce();
        cleansignal = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++; if (busy !== 1'b1 || settled !== 1'b0 || noisysignal !== g_pre) begin
                n_fail++; $display("FAIL bounce_window k=%0d: got n=%b b=%b s=%b expected n=%b b=1 s=0", k, noisysignal, busy, settled, g_pre);
            end
        end
        step();
        n_checks++; if (noisysignal !== 1'b1 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bounce_settle: got n=%b b=%b s=%b expected n=1 b=0 s=1", noisysignal, busy, settled);
        end
        step();
        n_checks++; if (noisysignal !== 1'b1 || settled !== 1'b0) begin
            n_fail++; $display("FAIL bounce_after: got n=%b s=%b expected n=1 s=0", noisysignal, settled);
        end
    endtask

    task automatic test_reversal();
        bounceenable = 1'b0; cleansignal = 1'b0;
        step(); step();
        bounceenable = 1'b1; cleansignal = 1'b1;
        step(); step(); step();        // E, E+1, E+2
        cleansignal = 1'b0;
        for (int k = 3; k <= 10; k++) begin
            step();
            n_checks++; if (busy !== 1'b1 || settled !== 1'b0 || noisysignal !== g_pre) begin
                n_fail++; $display("FAIL reversal_window E+%0d: got n=%b b=%b s=%b expected n=%b b=1 s=0", k, noisysignal, busy, settled, g_pre);
            end
        end
        step();                        // E+11
        n_checks++; if (noisysignal !== 1'b0 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reversal_settle: got n=%b b=%b s=%b expected n=0 b=0 s=1", noisysignal, busy, settled);
        end
    endtask

    task automatic test_settle_reversal();
        bounceenable = 1'b1; cleansignal = 1'b1;
        for (int k = 0; k < 8; k++) step();   // E..E+7
        cleansignal = 1'b0;
        step();                                // E+8: reversal beats settling
        n_checks++; if (busy !== 1'b1 || settled !== 1'b0 || noisysignal !== g_pre) begin
            n_fail++; $display("FAIL edge_reversal: got n=%b b=%b s=%b expected n=%b b=1 s=0", noisysignal, busy, settled, g_pre);
        end
        for (int k = 0; k < 7; k++) begin
            step();
            n_checks++; if (busy !== 1'b1 || settled !== 1'b0) begin
                n_fail++; $display("FAIL edge_reversal_window k=%0d: got b=%b s=%b expected b=1 s=0", k, busy, settled);
            end
        end
        step();                                // E+16
        n_checks++; if (noisysignal !== 1'b0 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL edge_reversal_settle: got n=%b b=%b s=%b expected n=0 b=0 s=1", noisysignal, busy, settled);
        end
    endtask

    task automatic test_passthrough();
        bounceenable = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cleansignal = ~cleansignal;
            step();
            n_checks++; if (noisysignal !== cleansignal || settled !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL pass_edge t=%0d: got n=%b b=%b s=%b expected n=%b b=0 s=1", t, noisysignal, busy, settled, cleansignal);
            end
            for (int k = 0; k < 3; k++) begin
                step();
                n_checks++; if (noisysignal !== cleansignal || settled !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL pass_hold t=%0d k=%0d: got n=%b b=%b s=%b expected n=%b b=0 s=0", t, k, noisysignal, busy, settled, cleansignal);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        bounceenable = 1'b1; cleansignal = 1'b1;
        step();                                // E
        bounceenable = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step();
            n_checks++; if (busy !== 1'b1 || settled !== 1'b0) begin
                n_fail++; $display("FAIL endrop_window E+%0d: got b=%b s=%b expected b=1 s=0", k, busy, settled);
            end
        end
        step();
        n_checks++; if (noisysignal !== 1'b1 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL endrop_settle: got n=%b b=%b s=%b expected n=1 b=0 s=1", noisysignal, busy, settled);
        end
        cleansignal = 1'b0;
        step();
        n_checks++; if (noisysignal !== 1'b0 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL endrop_pass: got n=%b b=%b s=%b expected n=0 b=0 s=1", noisysignal, busy, settled);
        end
    endtask

    task automatic test_reset_mid_bounce();
        bounceenable = 1'b1; cleansignal = 1'b1;
        step(); step(); step(); step();        // E..E+3
        reset = 1'b1;
        step();                                // E+4
        n_checks++; if (noisysignal !== 1'b0 || busy !== 1'b0 || settled !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out: got n=%b b=%b s=%b expected 000", noisysignal, busy, settled);
        end
        n_checks++; if (dut.w_lfsr !== 8'hA5) begin
            n_fail++; $display("FAIL midreset_lfsr: got %h expected a5", dut.w_lfsr);
        end
        step();
        n_checks++; if (settled !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_hold: got b=%b s=%b expected 00", busy, settled);
        end
        reset = 1'b0;                          // clean still 1: seen as a change
        step();
        n_checks++; if (busy !== 1'b1 || noisysignal !== 1'b1 || settled !== 1'b0) begin
            n_fail++; $display("FAIL release_change: got n=%b b=%b s=%b expected n=1 b=1 s=0", noisysignal, busy, settled);
        end
        for (int k = 1; k < 8; k++) begin
            step();
            n_checks++; if (busy !== 1'b1 || noisysignal !== g_pre) begin
                n_fail++; $display("FAIL release_window k=%0d: got n=%b b=%b expected n=%b b=1", k, noisysignal, busy, g_pre);
            end
        end
        step();
        n_checks++; if (noisysignal !== 1'b1 || settled !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL release_settle: got n=%b b=%b s=%b expected n=1 b=0 s=1", noisysignal, busy, settled);
        end
    endtask

    task automatic test_random_transitions();
        int gap;
        int pulses;
        bounceenable = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cleansignal = ~cleansignal;
            gap = $urandom_range(12, 20);
            pulses = 0;
            for (int k = 0; k < gap; k++) begin
                step();
                if (settled === 1'b1) pulses++;
                n_checks++; if ((busy & settled) !== 1'b0) begin
                    n_fail++; $display("FAIL busy_and_settled t=%0d k=%0d: got b=%b s=%b expected not both", t, k, busy, settled);
                end
                n_checks++; if (dut.r_counter > 4'd7) begin
                    n_fail++; $display("FAIL counter_range t=%0d: got %0d expected <=7", t, dut.r_counter);
                end
            end
            n_checks++; if (pulses !== 1) begin
                n_fail++; $display("FAIL settle_count t=%0d: got %0d expected 1", t, pulses);
            end
            n_checks++; if (noisysignal !== cleansignal) begin
                n_fail++; $display("FAIL final_level t=%0d: got %b expected %b", t, noisysignal, cleansignal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_reversal();
        test_settle_reversal();
        test_passthrough();
        test_enable_drop();
        test_reset_mid_bounce();
        test_random_transitions();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bounce_generator
`default_nettype wire
